// File: rtl/csa_accumulator_pkg.sv
// rtl/csa_accumulator_pkg.sv - shared types, widths and counter helper for csa_accumulator
//
// Purpose: datapath width, accumulator state encoding and the saturating
//          increment used for the per-window beat counter.
// Ports:   none (package).

package csa_accumulator_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Increment v, clamping at the largest value representable in w bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/csa_accumulator_csa.sv
// rtl/csa_accumulator_csa.sv - 32-bit 3:2 carry-save compressor
//
// Purpose: reduces three 32-bit operands to a redundant sum/carry pair whose
//          arithmetic total equals in1 + in2 + in3 mod 2^32.
// Ports:   in1, in2, in3 - operands
//          sum           - bitwise XOR of the operands
//          carry         - majority vector already shifted left by one; bit 0
//                          is zero and the bit-31 carry-out is dropped

module carrySaveAdder32bit
  import csa_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] carry
);

  assign sum = in1 ^ in2 ^ in3;

  // Only the low 31 majority bits matter; the top one would carry out of 2^32.
  assign carry = {(in1[DATA_W-2:0] & in2[DATA_W-2:0]) |
                  (in1[DATA_W-2:0] & in3[DATA_W-2:0]) |
                  (in2[DATA_W-2:0] & in3[DATA_W-2:0]), 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save streaming window accumulator
//
// Purpose: sums one window of 32-bit operands (one per cycle) in redundant
//          sum/carry form, resolves it with a single carry-propagate add and
//          presents the result and saturating beat count on a valid/ready port.
// Ports:   clk, reset           - clock, synchronous active-high reset
//          in_valid/in_ready    - operand handshake; in_data operand,
//                                 in_last marks the final beat of a window
//          out_valid/out_ready  - result handshake
//          out_data             - window sum mod 2^32
//          out_count            - beats in the window, saturating

module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [COUNT_W-1:0] out_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0]  carry_q, carry_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] ocnt_q, ocnt_d;
  logic [DATA_W-1:0]  csa_s, csa_c;
  logic               accept;

  carrySaveAdder32bit u_csa (
    .in1   (sum_q),
    .in2   (carry_q),
    .in3   (in_data),
    .sum   (csa_s),
    .carry (csa_c)
  );

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && in_last) state_d = RESOLVE;
      RESOLVE: state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs depend on state only, so in_ready never follows out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ACCUM:   in_ready  = 1'b1;
      RESOLVE: ;
      OUTPUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ocnt_d  = ocnt_q;
    if (state_q == ACCUM && accept) begin
      sum_d   = csa_s;
      carry_d = csa_c;
      cnt_d   = COUNT_W'(sat_inc(32'(cnt_q), COUNT_W));
    end else if (state_q == RESOLVE) begin
      // The only carry-propagate add; the redundant state is cleared so the
      // next window starts from zero.
      res_d   = sum_q + carry_q;
      ocnt_d  = cnt_q;
      sum_d   = '0;
      carry_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ocnt_q  <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign out_data  = res_q;
  assign out_count = ocnt_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - directed self-checking bench for csa_accumulator

module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.COUNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one beat at the falling edge; it is taken on the next rising edge.
  task automatic beat(input logic [31:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
  endtask

  // Called right after the last beat was presented, with out_ready = 1.
  task automatic finish_window(input string tag, input logic [31:0] exp_d, input logic [7:0] exp_c);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_resolve_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_resolve_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_count"}, 32'(out_count), 32'(exp_c));
    @(negedge clk);
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    reset = 1'b0;

    // 1+2+3+4
    beat(32'd1, 1'b0);
    beat(32'd2, 1'b0);
    beat(32'd3, 1'b0);
    beat(32'd4, 1'b1);
    finish_window("sum4", 32'd10, 8'd4);

    // single negative beat
    beat(32'hFFFF_FFF6, 1'b1);
    finish_window("single", 32'hFFFF_FFF6, 8'd1);

    // 0x7FFFFFFF + 1 - 5 wraps through 0x80000000 to 0x7FFFFFFB
    beat(32'h7FFF_FFFF, 1'b0);
    beat(32'd1, 1'b0);
    beat(32'hFFFF_FFFB, 1'b1);
    finish_window("wrap", 32'h7FFF_FFFB, 8'd3);
    beat(32'd7, 1'b1);
    finish_window("cleared", 32'd7, 8'd1);

    // in_last without in_valid is ignored
    beat(32'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_data  = 32'd100;
    check("gap_ready", 32'(in_ready), 32'd1);
    beat(32'd6, 1'b1);
    finish_window("gap_last", 32'd10, 8'd2);

    // 300 ones: sum is exact, count saturates at 255
    for (int i = 0; i < 300; i++) beat(32'd1, (i == 299));
    finish_window("sat", 32'd300, 8'd255);

    // downstream stall
    out_ready = 1'b0;
    beat(32'd9, 1'b0);
    beat(32'd8, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("stall_valid0", 32'(out_valid), 32'd1);
    check("stall_data0", out_data, 32'd17);
    in_valid = 1'b1;
    in_data  = 32'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, 32'd17);
      check("stall_count", 32'(out_count), 32'd2);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    // The held 0x55 beat is taken only now, forming a one-beat window.
    finish_window("after_stall", 32'h55, 8'd1);

    // reset mid-window
    beat(32'd1, 1'b0);
    beat(32'd2, 1'b0);
    beat(32'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_data", out_data, 32'd0);
    check("rstmid_count", 32'(out_count), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_out", 32'(out_valid), 32'd0);
    end
    beat(32'd5, 1'b0);
    beat(32'd5, 1'b1);
    finish_window("post_rst", 32'd10, 8'd2);

    // reset while a result is pending
    out_ready = 1'b0;
    beat(32'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("rstout_pending", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    check("rstout_valid", 32'(out_valid), 32'd0);
    check("rstout_data", out_data, 32'd0);
    check("rstout_count", 32'(out_count), 32'd0);
    check("rstout_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
